// File: rtl/int_arbiter_if.sv
// Handshake bundle between the interrupt arbiter and the 6502C control FSM.
// The slave modport is the arbiter's view; the master modport is the FSM/pin side.
interface int_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
);
    logic               RDY;
    logic [NUM_SRC-1:0] intIn;
    logic               iFlag;
    logic               T1now;
    logic               intAck;
    logic               intDone;
    logic               intReq;
    logic [SEL_W-1:0]   intSel;
    logic [15:0]        intVec;
    logic [NUM_SRC-1:0] handled;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output RDY, intIn, iFlag, T1now, intAck, intDone,
        input  intReq, intSel, intVec, handled, pending
    );

    modport slave (
        input  RDY, intIn, iFlag, T1now, intAck, intDone,
        output intReq, intSel, intVec, handled, pending
    );
endinterface

// File: rtl/int_arbiter.sv
// Prioritised interrupt arbiter/sequencer for the 6502C control FSM.
// Per-channel edge/level sensing and masking, requests taken only at instruction boundaries.
module int_arbiter #(
    parameter int                      NUM_SRC   = 4,
    parameter int                      SEL_W     = 2,
    parameter logic [NUM_SRC-1:0]      EDGE_MASK = 4'b0010,
    parameter logic [NUM_SRC-1:0]      MASKABLE  = 4'b1100,
    parameter logic [NUM_SRC*16-1:0]   VEC_TABLE = {16'hFFFE, 16'hFFFE, 16'hFFFA, 16'hFFFC}
) (
    input  logic         phi1,
    input  logic         rst,
    int_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]         stateReg;
    logic               intReqReg;
    logic [SEL_W-1:0]   intSelReg;
    logic [15:0]        intVecReg;
    logic [NUM_SRC-1:0] handledReg;
    logic [NUM_SRC-1:0] pendingReg;
    logic [NUM_SRC-1:0] prevIn;

    logic [NUM_SRC-1:0] enabled;
    logic               anyEn;
    logic [SEL_W-1:0]   winIdx;
    logic [15:0]        winVec;
    logic               doneHit;
    logic [NUM_SRC-1:0] completeVec;

    assign enabled = pendingReg & ~(MASKABLE & {NUM_SRC{bus.iFlag}});
    assign anyEn   = |enabled;

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        winIdx = '0;
        winVec = VEC_TABLE[15:0];
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                winIdx = SEL_W'(i);
                winVec = VEC_TABLE[16*i +: 16];
            end
        end
    end

    assign doneHit     = bus.RDY && (stateReg == SERVICE) && bus.intDone;
    assign completeVec = doneHit ? (NUM_SRC'(1) << intSelReg) : '0;

    // prevIn resets high so a line held asserted through reset is not seen as an edge.
    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) begin
            prevIn <= '1;
        end else begin
            prevIn <= bus.intIn;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            if (EDGE_MASK[gi]) begin : g_edge
                // A fresh edge beats the completion clear, so a re-fire during service is kept.
                always_ff @(posedge phi1 or posedge rst) begin
                    if (rst) begin
                        pendingReg[gi] <= 1'b0;
                    end else if (bus.intIn[gi] && !prevIn[gi]) begin
                        pendingReg[gi] <= 1'b1;
                    end else if (completeVec[gi]) begin
                        pendingReg[gi] <= 1'b0;
                    end
                end
            end else begin : g_level
                always_ff @(posedge phi1 or posedge rst) begin
                    if (rst) begin
                        pendingReg[gi] <= 1'b0;
                    end else begin
                        pendingReg[gi] <= bus.intIn[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) begin
            stateReg   <= IDLE;
            intReqReg  <= 1'b0;
            intSelReg  <= '0;
            intVecReg  <= VEC_TABLE[15:0];
            handledReg <= '0;
        end else begin
            handledReg <= completeVec;
            if (bus.RDY) begin
                case (stateReg)
                    IDLE: begin
                        if (bus.T1now && anyEn) begin
                            intSelReg <= winIdx;
                            intVecReg <= winVec;
                            intReqReg <= 1'b1;
                            stateReg  <= REQ;
                        end
                    end
                    REQ: begin
                        if (bus.intAck) begin
                            intReqReg <= 1'b0;
                            stateReg  <= SERVICE;
                        end else if (!anyEn) begin
                            intReqReg <= 1'b0;
                            stateReg  <= IDLE;
                        end else if (winIdx < intSelReg) begin
                            // Higher-priority arrival before the FSM commits takes over the request.
                            intSelReg <= winIdx;
                            intVecReg <= winVec;
                        end
                    end
                    SERVICE: begin
                        if (bus.intDone) begin
                            stateReg <= IDLE;
                        end
                    end
                    default: begin
                        intReqReg <= 1'b0;
                        stateReg  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.intReq  = intReqReg;
    assign bus.intSel  = intSelReg;
    assign bus.intVec  = intVecReg;
    assign bus.handled = handledReg;
    assign bus.pending = pendingReg;

endmodule
